// File: rtl/pc_gen_if.sv
// pc_gen_if -- bundle between the control FSM / decoder and the PC generator.
//   master : drives pc_prectl, npc_sel, br_cond, br_off, j_idx, rs_val;
//            observes pc, id_pc, epc, id_bd
//   slave  : the PC generator (mirror of master)
interface pc_gen_if;
    logic [3:0]  pc_prectl;
    logic [2:0]  npc_sel;
    logic        br_cond;
    logic [15:0] br_off;
    logic [25:0] j_idx;
    logic [31:0] rs_val;
    logic [31:0] pc;
    logic [31:0] id_pc;
    logic [31:0] epc;
    logic        id_bd;

    modport master (
        output pc_prectl, npc_sel, br_cond, br_off, j_idx, rs_val,
        input  pc, id_pc, epc, id_bd
    );

    modport slave (
        input  pc_prectl, npc_sel, br_cond, br_off, j_idx, rs_val,
        output pc, id_pc, epc, id_bd
    );
endinterface

// File: rtl/pc_gen.sv
// pc_gen -- program-counter generator for the mips789 core.
// Produces the fetch address, tracks the decode-stage PC and its delay-slot
// flag, and captures the restart address (epc) when an interrupt is taken.
//   clk : clock, rising edge
//   rst : synchronous, active-low reset
//   bus : pc_gen_if slave
//         in  pc_prectl[3:0], npc_sel[2:0], br_cond, br_off[15:0],
//             j_idx[25:0], rs_val[31:0]
//         out pc[31:0], id_pc[31:0], epc[31:0], id_bd (all registered)
module pc_gen (
    input logic       clk,
    input logic       rst,
    pc_gen_if.slave   bus
);
    localparam logic [31:0] RST_VEC = 32'h0000_0000;
    localparam logic [31:0] IRQ_VEC = 32'h0000_0050;
    localparam logic [3:0]  PC_IGN  = 4'd1;
    localparam logic [3:0]  PC_KEP  = 4'd2;
    localparam logic [3:0]  PC_IRQ  = 4'd4;
    localparam logic [3:0]  PC_RST  = 4'd8;

    logic [31:0] pc_q, id_pc_q, epc_q;
    logic        id_bd_q;
    logic [31:0] pc_d, id_pc_d, epc_d;
    logic        id_bd_d;
    logic [31:0] seq_pc;
    logic [31:0] br_tgt;
    logic [31:0] npc;
    logic        is_ctl;

    assign seq_pc = pc_q + 32'd4;
    // Branch base is the delay-slot address, which is the current fetch pc.
    assign br_tgt = pc_q + {{14{bus.br_off[15]}}, bus.br_off, 2'b00};

    always_comb begin
        npc    = seq_pc;
        is_ctl = 1'b0;
        case (bus.npc_sel)
            3'd1: begin
                npc    = bus.br_cond ? br_tgt : seq_pc;
                is_ctl = 1'b1;
            end
            3'd2: begin
                npc    = {pc_q[31:28], bus.j_idx, 2'b00};
                is_ctl = 1'b1;
            end
            3'd3: begin
                npc    = bus.rs_val;
                is_ctl = 1'b1;
            end
            3'd4: begin
                npc    = epc_q;
                is_ctl = 1'b1;
            end
            default: begin
                npc    = seq_pc;
                is_ctl = 1'b0;
            end
        endcase
    end

    // Any code other than the four legal one-hot values acts as a soft reset.
    always_comb begin
        pc_d    = RST_VEC;
        id_pc_d = RST_VEC;
        epc_d   = 32'd0;
        id_bd_d = 1'b0;
        case (bus.pc_prectl)
            PC_IRQ: begin
                // An interrupted delay slot must restart at its branch.
                epc_d   = id_bd_q ? (id_pc_q - 32'd4) : id_pc_q;
                pc_d    = IRQ_VEC;
                id_pc_d = IRQ_VEC;
                id_bd_d = 1'b0;
            end
            PC_KEP: begin
                pc_d    = pc_q;
                id_pc_d = id_pc_q;
                epc_d   = epc_q;
                id_bd_d = id_bd_q;
            end
            PC_IGN: begin
                pc_d    = npc;
                id_pc_d = pc_q;
                epc_d   = epc_q;
                id_bd_d = is_ctl;
            end
            default: begin
                pc_d    = RST_VEC;
                id_pc_d = RST_VEC;
                epc_d   = 32'd0;
                id_bd_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q    <= RST_VEC;
            id_pc_q <= RST_VEC;
            epc_q   <= 32'd0;
            id_bd_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            id_pc_q <= id_pc_d;
            epc_q   <= epc_d;
            id_bd_q <= id_bd_d;
        end
    end

    assign bus.pc    = pc_q;
    assign bus.id_pc = id_pc_q;
    assign bus.epc   = epc_q;
    assign bus.id_bd = id_bd_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen -- directed-vector bench for pc_gen with a queue-based scoreboard.
// The driver applies one vector per cycle on the falling edge and pushes the
// hand-computed register values expected after the next rising edge; the
// monitor pops and compares shortly after each rising edge.
module tb_pc_gen;
    localparam logic [3:0] IGN = 4'd1;
    localparam logic [3:0] KEP = 4'd2;
    localparam logic [3:0] IRQ = 4'd4;
    localparam logic [3:0] RST = 4'd8;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] id_pc;
        logic [31:0] epc;
        logic        id_bd;
    } exp_t;

    logic clk;
    logic rst;
    pc_gen_if bus ();

    pc_gen u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s.%s: got %h, expected %h", name, fld, act, exp);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "pc",    bus.pc,    e.pc);
                chk(e.name, "id_pc", bus.id_pc, e.id_pc);
                chk(e.name, "epc",   bus.epc,   e.epc);
                chk(e.name, "id_bd", {31'd0, bus.id_bd}, {31'd0, e.id_bd});
            end
        end
    end

    task automatic vec(input string name, input logic r, input logic [3:0] ctl,
                       input logic [2:0] sel, input logic cond,
                       input logic [15:0] off, input logic [25:0] jidx,
                       input logic [31:0] rs,
                       input logic [31:0] e_pc, input logic [31:0] e_id,
                       input logic [31:0] e_epc, input logic e_bd);
        exp_t e;
        @(negedge clk);
        rst           = r;
        bus.pc_prectl = ctl;
        bus.npc_sel   = sel;
        bus.br_cond   = cond;
        bus.br_off    = off;
        bus.j_idx     = jidx;
        bus.rs_val    = rs;
        e.name  = name;
        e.pc    = e_pc;
        e.id_pc = e_id;
        e.epc   = e_epc;
        e.id_bd = e_bd;
        exp_q.push_back(e);
    endtask

    initial begin : driver
        int wait_cyc;
        rst           = 1'b0;
        bus.pc_prectl = IGN;
        bus.npc_sel   = 3'd0;
        bus.br_cond   = 1'b0;
        bus.br_off    = 16'd0;
        bus.j_idx     = 26'd0;
        bus.rs_val    = 32'd0;

        //   name        rst ctl  sel  cond off       jidx     rs_val          pc            id_pc         epc         bd
        vec("reset",     0, IGN, 3'd1, 1, 16'h0010, 26'h0,  32'h0,        32'h0,        32'h0,        32'h0,   0);
        vec("seq0",      1, IGN, 3'd0, 0, 16'h0,    26'h0,  32'h0,        32'h4,        32'h0,        32'h0,   0);
        vec("seq1",      1, IGN, 3'd0, 0, 16'h0,    26'h0,  32'h0,        32'h8,        32'h4,        32'h0,   0);
        vec("seq2",      1, IGN, 3'd0, 0, 16'h0,    26'h0,  32'h0,        32'hC,        32'h8,        32'h0,   0);
        vec("illegal3",  1, 4'd3, 3'd0, 0, 16'h0,   26'h0,  32'h0,        32'h0,        32'h0,        32'h0,   0);
        vec("jr100",     1, IGN, 3'd3, 0, 16'h0,    26'h0,  32'h100,      32'h100,      32'h0,        32'h0,   1);
        vec("br_taken",  1, IGN, 3'd1, 1, 16'hFFFE, 26'h0,  32'h0,        32'h0F8,      32'h100,      32'h0,   1);
        vec("jr100b",    1, IGN, 3'd3, 0, 16'h0,    26'h0,  32'h100,      32'h100,      32'h0F8,      32'h0,   1);
        vec("br_not",    1, IGN, 3'd1, 0, 16'hFFFE, 26'h0,  32'h0,        32'h104,      32'h100,      32'h0,   1);
        vec("jr3000",    1, IGN, 3'd3, 0, 16'h0,    26'h0,  32'h3000_0010, 32'h3000_0010, 32'h104,    32'h0,   1);
        vec("j_abs",     1, IGN, 3'd2, 0, 16'h0,    26'h40, 32'h0,        32'h3000_0100, 32'h3000_0010, 32'h0, 1);
        vec("jr2000",    1, IGN, 3'd3, 0, 16'h0,    26'h0,  32'h2000,     32'h2000,     32'h3000_0100, 32'h0,  1);
        vec("jr200",     1, IGN, 3'd3, 0, 16'h0,    26'h0,  32'h200,      32'h200,      32'h2000,     32'h0,   1);
        vec("seq204",    1, IGN, 3'd0, 0, 16'h0,    26'h0,  32'h0,        32'h204,      32'h200,      32'h0,   0);
        vec("irq_nobd",  1, IRQ, 3'd3, 1, 16'h0,    26'h0,  32'h999,      32'h50,       32'h50,       32'h200, 0);
        vec("jr204",     1, IGN, 3'd3, 0, 16'h0,    26'h0,  32'h204,      32'h204,      32'h50,       32'h200, 1);
        vec("jr300",     1, IGN, 3'd3, 0, 16'h0,    26'h0,  32'h300,      32'h300,      32'h204,      32'h200, 1);
        vec("irq_bd",    1, IRQ, 3'd0, 0, 16'h0,    26'h0,  32'h0,        32'h50,       32'h50,       32'h200, 0);
        vec("eret",      1, IGN, 3'd4, 0, 16'h0,    26'h0,  32'h0,        32'h200,      32'h50,       32'h200, 1);
        vec("seq_a",     1, IGN, 3'd0, 0, 16'h0,    26'h0,  32'h0,        32'h204,      32'h200,      32'h200, 0);
        vec("seq_b",     1, IGN, 3'd0, 0, 16'h0,    26'h0,  32'h0,        32'h208,      32'h204,      32'h200, 0);
        vec("irq_eret",  1, IRQ, 3'd4, 0, 16'h0,    26'h0,  32'h0,        32'h50,       32'h50,       32'h204, 0);
        vec("jr40",      1, IGN, 3'd3, 0, 16'h0,    26'h0,  32'h40,       32'h40,       32'h50,       32'h204, 1);
        for (int i = 0; i < 33; i++)
            vec("stall",  1, KEP, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                16'($urandom), 26'($urandom), $urandom,
                32'h40, 32'h50, 32'h204, 1);
        vec("rst_stall", 0, KEP, 3'd4, 0, 16'h0,    26'h0,  32'h0,        32'h0,        32'h0,        32'h0,   0);
        vec("first_ign", 1, IGN, 3'd0, 0, 16'h0,    26'h0,  32'h0,        32'h4,        32'h0,        32'h0,   0);
        vec("jr_top",    1, IGN, 3'd3, 0, 16'h0,    26'h0,  32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h4,      32'h0,   1);
        vec("wrap",      1, IGN, 3'd0, 0, 16'h0,    26'h0,  32'h0,        32'h0,        32'hFFFF_FFFC, 32'h0,  0);
        vec("sel5",      1, IGN, 3'd5, 1, 16'h0100, 26'h3FF, 32'h1234,    32'h4,        32'h0,        32'h0,   0);
        vec("sel7",      1, IGN, 3'd7, 1, 16'h0100, 26'h3FF, 32'h1234,    32'h8,        32'h4,        32'h0,   0);
        vec("irq_b",     1, IRQ, 3'd0, 0, 16'h0,    26'h0,  32'h0,        32'h50,       32'h50,       32'h4,   0);
        vec("illegal6",  1, 4'd6, 3'd0, 0, 16'h0,   26'h0,  32'h0,        32'h0,        32'h0,        32'h0,   0);
        vec("irq_c",     1, IRQ, 3'd0, 0, 16'h0,    26'h0,  32'h0,        32'h50,       32'h50,       32'h0,   0);
        vec("softrst",   1, RST, 3'd3, 0, 16'h0,    26'h0,  32'h80,       32'h0,        32'h0,        32'h0,   0);

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_chk++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
